// File: rtl/ir_ctrl_pkg.sv
// Shared constants, FSM state types and frame helpers for the IR key decoder.
// No logic of its own; imported by ir_key_decoder and shoot_pulser.
// No handshake; all consumers sample these values statically.
package ir_ctrl_pkg;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h06;
  localparam logic [7:0] KEY_STOP  = 8'h02;
  localparam logic [7:0] KEY_SHOOT = 8'h05;

  localparam logic [15:0] DEFAULT_CUSTOM_CODE = 16'h6B86;

  localparam int TIMER_W = 23;
  localparam int HOLD_W  = 4;

  typedef logic [2:0] dir_t;
  localparam dir_t DIR_LEFT  = 3'b001;
  localparam dir_t DIR_RIGHT = 3'b010;
  localparam dir_t DIR_STOP  = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    APPLY = 2'd2
  } frame_state_t;

  typedef enum logic [1:0] {
    SH_IDLE = 2'd0,
    SH_ARM  = 2'd1,
    SH_FIRE = 2'd2
  } shoot_state_t;

  typedef struct packed {
    logic [7:0]  inv_key;
    logic [7:0]  key;
    logic [15:0] custom;
  } nec_frame_t;

  function automatic logic frame_ok(input nec_frame_t f, input logic [15:0] code);
    return (f.custom == code) && (f.inv_key == ~f.key);
  endfunction

  // Unlisted keys keep the current direction.
  function automatic dir_t key_to_dir(input logic [7:0] key, input dir_t cur);
    dir_t d;
    d = cur;
    case (key)
      KEY_LEFT:            d = DIR_LEFT;
      KEY_RIGHT:           d = DIR_RIGHT;
      KEY_STOP, KEY_SHOOT: d = DIR_STOP;
      default:             d = cur;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shoot_pulser.sv
// Turns a one-cycle shoot request into a shoot level lasting HOLD_TICKS tick intervals.
// Latency: request arms at the next edge; shoot rises on the first tick after arming.
// Backpressure: requests arriving while armed or firing are dropped.
module shoot_pulser import ir_ctrl_pkg::*; #(
  parameter int HOLD_TICKS = 2
) (
  input  logic master_clk,
  input  logic resetn,
  input  logic req,
  input  logic tick,
  output logic shoot
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(1);

  shoot_state_t state_q, state_d;
  logic [HOLD_W-1:0] cnt_q;

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SH_IDLE: if (req)  state_d = SH_ARM;
      SH_ARM:  if (tick) state_d = SH_FIRE;
      SH_FIRE: if (tick && (cnt_q == HOLD_LAST)) state_d = SH_IDLE;
      default: state_d = SH_IDLE;
    endcase
  end

  always_comb begin
    shoot = (state_q == SH_FIRE);
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (tick) begin
      if (state_q == SH_ARM) begin
        cnt_q <= HOLD_LOAD;
      end else if (state_q == SH_FIRE) begin
        cnt_q <= cnt_q - HOLD_LAST;
      end
    end
  end

endmodule

// File: rtl/ir_key_decoder.sv
// Validates NEC frames into one-hot direction levels, key status and a one-shot shoot pulse.
// Latency: outputs update 3 edges after data_ready rises (err_count after 2); no handshake.
// Backpressure: none; rising edges outside IDLE are dropped. IR_AUTOFIRE_EN disables repeat suppression.
module ir_key_decoder import ir_ctrl_pkg::*; #(
  parameter logic [15:0] CUSTOM_CODE      = DEFAULT_CUSTOM_CODE,
  parameter int          SHOOT_HOLD_TICKS = 2,
  parameter int          RELEASE_TIMEOUT  = 6_000_000
) (
  input  logic        master_clk,
  input  logic        resetn,
  input  logic        data_ready,
  input  logic [31:0] ir_data,
  input  logic        tick,
  output logic        left,
  output logic        right,
  output logic        stop,
  output logic        shoot,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic [7:0]  err_count
);

  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(RELEASE_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  frame_state_t state_q, state_d;
  nec_frame_t   frame_q;
  dir_t         dir_q;
  logic [TIMER_W-1:0] timer_q;
  logic dr_q;
  logic capture_en, apply_en, reject_en;
  logic is_repeat, shoot_req;

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      dr_q <= 1'b0;
    end else begin
      dr_q <= data_ready;
    end
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_ready && !dr_q) state_d = CHECK;
      CHECK:   state_d = frame_ok(frame_q, CUSTOM_CODE) ? APPLY : IDLE;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture_en = (state_q == IDLE) && data_ready && !dr_q;
    reject_en  = (state_q == CHECK) && !frame_ok(frame_q, CUSTOM_CODE);
    apply_en   = (state_q == APPLY);
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      frame_q <= '0;
    end else if (capture_en) begin
      frame_q <= ir_data;
    end
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      err_count <= '0;
    end else if (reject_en && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      dir_q    <= DIR_STOP;
      key_code <= '0;
    end else if (apply_en) begin
      dir_q    <= key_to_dir(frame_q.key, dir_q);
      key_code <= frame_q.key;
    end
  end

  // A reload in the expiry cycle takes priority, so key_valid never dips.
  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      timer_q   <= '0;
      key_valid <= 1'b0;
    end else if (apply_en) begin
      timer_q   <= TIMER_RELOAD;
      key_valid <= 1'b1;
    end else if (timer_q != '0) begin
      timer_q <= timer_q - TIMER_ONE;
      if (timer_q == TIMER_ONE) key_valid <= 1'b0;
    end
  end

`ifdef IR_AUTOFIRE_EN
  assign is_repeat = 1'b0;
`else
  // key_valid/key_code still hold the previous frame's status during APPLY.
  assign is_repeat = key_valid && (key_code == KEY_SHOOT);
`endif

  assign shoot_req = apply_en && (frame_q.key == KEY_SHOOT) && !is_repeat;

  shoot_pulser #(
    .HOLD_TICKS(SHOOT_HOLD_TICKS)
  ) u_shoot_pulser (
    .master_clk(master_clk),
    .resetn    (resetn),
    .req       (shoot_req),
    .tick      (tick),
    .shoot     (shoot)
  );

  assign left  = dir_q[0];
  assign right = dir_q[1];
  assign stop  = dir_q[2];

endmodule

// File: tb/tb_ir_key_decoder.sv
// Scoreboard bench for ir_key_decoder: frame results and shoot pulses are queued when driven.
// Short release timeout so expiry and repeat behaviour fit a brief run.
module tb_ir_key_decoder;

  localparam int T      = 200;
  localparam int HOLD   = 2;
  localparam int TICK_P = 16;
  localparam int PW     = HOLD * TICK_P;

  logic        master_clk = 1'b0;
  logic        resetn     = 1'b1;
  logic        data_ready = 1'b0;
  logic        tick       = 1'b0;
  logic [31:0] ir_data    = '0;
  logic        left, right, stop, shoot, key_valid;
  logic [7:0]  key_code, err_count;

  ir_key_decoder #(
    .CUSTOM_CODE     (16'h6B86),
    .SHOOT_HOLD_TICKS(HOLD),
    .RELEASE_TIMEOUT (T)
  ) dut (
    .master_clk(master_clk),
    .resetn    (resetn),
    .data_ready(data_ready),
    .ir_data   (ir_data),
    .tick      (tick),
    .left      (left),
    .right     (right),
    .stop      (stop),
    .shoot     (shoot),
    .key_valid (key_valid),
    .key_code  (key_code),
    .err_count (err_count)
  );

  always #10 master_clk = ~master_clk;

  typedef struct {
    int         due;
    logic       chk_kv;
    logic [2:0] dir;
    logic [7:0] code;
    logic [7:0] err;
  } exp_t;

  exp_t       sbq[$];
  int         pq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] m_dir  = 3'b100;
  logic [7:0] m_code = '0;
  logic [7:0] m_err  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge master_clk);
    cyc++;
  end

  initial forever begin
    @(posedge master_clk);
    #1 tick = (cyc % TICK_P == 0);
  end

  initial begin : sb_mon
    exp_t e;
    forever begin
      @(negedge master_clk);
      if (resetn) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
          e = sbq.pop_front();
          check("sb_due", cyc, e.due);
          check("dir", {stop, right, left}, e.dir);
          check("key_code", key_code, e.code);
          check("err_count", err_count, e.err);
          if (e.chk_kv) check("key_valid", key_valid, 1);
        end
      end
    end
  end

  initial begin : pulse_mon
    logic prev;
    int   start;
    prev  = 1'b0;
    start = 0;
    forever begin
      @(negedge master_clk);
      if (!resetn) begin
        prev = 1'b0;
      end else begin
        if (shoot && !prev) start = cyc;
        if (!shoot && prev) begin
          if (pq.size() == 0) check("pulse_unexpected", 1, 0);
          else check("pulse_width", cyc - start, pq.pop_front());
        end
        prev = shoot;
      end
    end
  end

  task automatic send(input logic [31:0] f, input bit shot, output int at);
    exp_t e;
    logic ok;
    @(posedge master_clk);
    #1;
    ir_data    = f;
    data_ready = 1'b1;
    at         = cyc;
    ok = (f[15:0] == 16'h6B86) && (f[31:24] == ~f[23:16]);
    if (ok) begin
      m_code = f[23:16];
      case (m_code)
        8'h04:        m_dir = 3'b001;
        8'h06:        m_dir = 3'b010;
        8'h02, 8'h05: m_dir = 3'b100;
        default:      m_dir = m_dir;
      endcase
      e.due    = cyc + 3;
      e.chk_kv = 1'b1;
      if (shot) pq.push_back(PW);
    end else begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      e.due    = cyc + 2;
      e.chk_kv = 1'b0;
    end
    e.dir  = m_dir;
    e.code = m_code;
    e.err  = m_err;
    sbq.push_back(e);
    repeat (2) @(posedge master_clk);
    #1 data_ready = 1'b0;
    repeat (2) @(posedge master_clk);
    #1;
  endtask

  task automatic model_reset();
    m_dir  = 3'b100;
    m_code = '0;
    m_err  = '0;
    sbq.delete();
    pq.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_left"}, left, 0);
    check({tag, "_right"}, right, 0);
    check({tag, "_stop"}, stop, 1);
    check({tag, "_shoot"}, shoot, 0);
    check({tag, "_key_valid"}, key_valid, 0);
    check({tag, "_key_code"}, key_code, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin : watchdog
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int at, n1;
    #2 resetn = 1'b0;
    #1 reset_checks("por");
    repeat (3) @(posedge master_clk);
    #1 resetn = 1'b1;

    // Rejected frames leave outputs alone and bump err_count.
    send(32'hFB041234, 1'b0, at);
    send(32'hFF046B86, 1'b0, at);
    check("err_two", err_count, 2);

    send(32'hFB046B86, 1'b0, at);
    send(32'hF9066B86, 1'b0, at);
    send(32'hFD026B86, 1'b0, at);
    send(32'hEF106B86, 1'b0, at);

    // Shoot, held repeat, then a fresh press after the release timeout.
    send(32'hFA056B86, 1'b1, at);
    repeat (50) @(posedge master_clk);
`ifdef IR_AUTOFIRE_EN
    send(32'hFA056B86, 1'b1, at);
`else
    send(32'hFA056B86, 1'b0, at);
`endif
    repeat (300) @(posedge master_clk);
    send(32'hFA056B86, 1'b1, at);
    for (int i = 0; i < 300 && pq.size() > 0; i++) @(posedge master_clk);
    #1 check("pulse_wait", pq.size(), 0);

    for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 32'hFB041234 : 32'hFF046B86, 1'b0, at);
    check("err_sat", err_count, 255);

    // Second APPLY lands exactly on the expiry edge of the first.
    send(32'hFB046B86, 1'b0, n1);
    repeat (n1 + T - 1 - cyc) @(posedge master_clk);
    #1;
    send(32'hF9066B86, 1'b0, at);
    repeat (at + 3 + T - 1 - cyc) @(posedge master_clk);
    #1 check("kv_before_expiry", key_valid, 1);
    @(posedge master_clk);
    #1 check("kv_after_expiry", key_valid, 0);

    // Reset while firing.
    send(32'hFA056B86, 1'b0, at);
    for (int i = 0; i < 80 && !shoot; i++) begin
      @(posedge master_clk);
      #1;
    end
    check("shoot_rise", shoot, 1);
    #3 resetn = 1'b0;
    model_reset();
    #1 reset_checks("rst_fire");
    repeat (2) @(posedge master_clk);
    #1 resetn = 1'b1;
    send(32'hFB046B86, 1'b0, at);

    // Reset while the frame sits in CHECK; that frame must be lost.
    @(posedge master_clk);
    #1;
    ir_data    = 32'hF9066B86;
    data_ready = 1'b1;
    @(posedge master_clk);
    #1;
    resetn     = 1'b0;
    data_ready = 1'b0;
    model_reset();
    #1 reset_checks("rst_check");
    repeat (2) @(posedge master_clk);
    #1 resetn = 1'b1;
    repeat (4) @(posedge master_clk);
    #1 reset_checks("rst_lost");
    send(32'hF9066B86, 1'b0, at);

    repeat (10) @(posedge master_clk);
    #1;
    check("sb_drain", sbq.size(), 0);
    check("pulse_drain", pq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
